axi_fault_monitor: RTL and testbench
====================================

# axi_fault_monitor

Synthesizable, parametrised AXI4 response-fault monitor that passively snoops one master/slave link (no handshake signals are driven). It tracks outstanding read and write addresses in order, and flags any non-OKAY R/B response as a registered fault pulse. It keeps a sticky first-fault record (address, ID, resp, direction), saturating per-direction fault counters and protocol-error flags for debug CSRs or trap logic.

## Interface
- `ADDR_W`, 32, address width
- `ID_W`, 4, AXI ID width
- `DEPTH`, 4, outstanding transactions tracked per direction (power of 2, ≥2)
- `CNT_W`, 8, fault counter width
- `EXOKAY_OK`, 1, when 1 treat resp 2'b01 as success
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset; one clock, synchronous, active-high
- `i_clr`  in  1  clear record, counters, sticky flags
- `awvalid`, `awready`  in  1  AW handshake; `awaddr` in ADDR_W; `awid` in ID_W
- `arvalid`, `arready`  in  1  AR handshake; `araddr` in ADDR_W; `arid` in ID_W
- `bvalid`, `bready`  in  1; `bresp` in 2; `bid` in ID_W
- `rvalid`, `rready`, `rlast`  in  1; `rresp` in 2; `rid` in ID_W
- `o_fault`  out  1  one-cycle pulse per cycle containing ≥1 faulting response beat
- `o_rec_vld`  out  1  sticky: first-fault record valid
- `o_rec_addr`  out  ADDR_W; `o_rec_id`  out  ID_W; `o_rec_resp`  out  2; `o_rec_wr`  out  1 (1 = write)
- `o_rd_cnt`, `o_wr_cnt`  out  CNT_W  saturating fault counts
- `o_ovf`  out  1  sticky: address handshake accepted while tracker full
- `o_orphan`  out  1  sticky: response beat with empty tracker

## Operation
- Each direction has an in-order tracker FIFO of {addr, id}. Push on an address handshake (`valid&&ready`).
- Read tracker pops on an `rvalid&&rready&&rlast` beat. Write tracker pops on a `bvalid&&bready` beat.
- Fault condition: the response beat handshakes with resp ≠ OKAY. Resp 01 is excluded when `EXOKAY_OK`=1. Each R beat is checked, not only the last.
- Record address and ID come from the tracker head, not from `rid`/`bid`. A mismatch between head ID and `rid`/`bid` sets `o_orphan`. Out-of-order IDs are unsupported.
- First fault since reset/clear: latch the record and set `o_rec_vld`. Later faults leave the record unchanged but still pulse and count.
- Read and write fault in the same cycle: the read fault is recorded, both counters increment, one `o_fault` pulse.
- Counters saturate at 2^CNT_W−1.
- Full tracker with push and no pop: set `o_ovf`, drop the push. Push and pop in the same cycle while full: legal, no overflow.
- Empty tracker with a pop: set `o_orphan`, record address = 0, no pointer movement. A push in the same cycle is still stored.
- `i_clr` clears the record, counters, `o_ovf` and `o_orphan`. It does not touch the trackers. A fault in the same cycle as `i_clr` wins: the record is loaded and the counter is set to 1.

## Timing
- All outputs are registered. `o_fault` and all record/counter/flag updates appear the cycle after the handshake edge (latency 1).
- Reset values: every output is 0, and both trackers are empty.
- Reset asserted mid-transaction discards all tracker contents. Responses arriving after reset for pre-reset addresses are reported as orphans.
- There is no combinational path from any input to any output.

## Structure
- Package `axi_fault_pkg`:
  - resp encodings OKAY/EXOKAY/SLVERR/DECERR
  - record struct {addr, id, resp, wr}
  - `is_fault(resp, exokay_ok)` function
- Sub-module `axi_fault_fifo` (sync FIFO, WIDTH, DEPTH; push/pop/full/empty/head; same-cycle push+pop when full). Instantiated twice: read and write.

## Test plan
- AR addr 0x8000_0000 id 3, len 0, R rresp=10 rlast -> `o_fault` pulse 1 cycle after, record {0x8000_0000, 3, 10, wr=0}, `o_rd_cnt`=1.
- AW 0x1000 then AW 0x2000, B OKAY then B DECERR -> record addr 0x2000, resp 11, wr=1, `o_wr_cnt`=1.
- Same-cycle R SLVERR (addr 0xA0) and B DECERR (addr 0xB0) -> record read 0xA0, both counts 1, single pulse.
- DEPTH+1 ARs without R -> `o_ovf`=1. Then push+pop while full -> no further change, FIFO order preserved.
- R beat with empty tracker -> `o_orphan`=1. Then `i_clr` -> all flags/counters 0; 2^CNT_W+3 faults -> counter = 2^CNT_W−1.
- `i_clr` coincident with an R SLVERR -> `o_rec_vld`=1, `o_rd_cnt`=1. Then `i_rst` with 2 ARs outstanding -> outputs 0, trackers empty.

Source files
------------

// File: rtl/axi_fault_pkg.sv
// Shared AXI response encodings, the debug fault-record layout and the
// response classification used by the fault monitor.
package axi_fault_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    localparam int REC_ADDR_W = 64;
    localparam int REC_ID_W   = 16;

    // CSR-facing record view, wide enough for every supported ADDR_W / ID_W
    typedef struct packed {
        logic [REC_ADDR_W-1:0] addr;
        logic [REC_ID_W-1:0]   id;
        resp_e                 resp;
        logic                  wr;
    } fault_rec_t;

    function automatic logic is_fault(input logic [1:0] resp, input logic exokay_ok);
        logic fault;
        case (resp)
            RESP_OKAY:   fault = 1'b0;
            RESP_EXOKAY: fault = !exokay_ok;
            default:     fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/axi_fault_fifo.sv
// In-order tracker FIFO: drops a push when full unless a pop frees the slot in
// the same cycle, and ignores a pop when empty.
module axi_fault_fifo
    import axi_fault_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (count_r == {(PTR_W + 1){1'b0}});
    assign full  = (count_r == CNT_FULL);
    assign head  = mem_r[rd_ptr_r];

    // Effective push/pop after full/empty qualification
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    // Pointer and occupancy update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/axi_fault_monitor.sv
// Passive AXI4 response-fault monitor: in-order address tracking per direction,
// registered fault pulse, sticky first-fault record, saturating counters, flags.
module axi_fault_monitor
    import axi_fault_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 4,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 8,
    parameter int EXOKAY_OK = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              awvalid,
    input  logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [ID_W-1:0]   awid,
    input  logic              arvalid,
    input  logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [ID_W-1:0]   arid,
    input  logic              bvalid,
    input  logic              bready,
    input  logic [1:0]        bresp,
    input  logic [ID_W-1:0]   bid,
    input  logic              rvalid,
    input  logic              rready,
    input  logic              rlast,
    input  logic [1:0]        rresp,
    input  logic [ID_W-1:0]   rid,
    output logic              o_fault,
    output logic              o_rec_vld,
    output logic [ADDR_W-1:0] o_rec_addr,
    output logic [ID_W-1:0]   o_rec_id,
    output logic [1:0]        o_rec_resp,
    output logic              o_rec_wr,
    output logic [CNT_W-1:0]  o_rd_cnt,
    output logic [CNT_W-1:0]  o_wr_cnt,
    output logic              o_ovf,
    output logic              o_orphan
);

    localparam int ENT_W = ADDR_W + ID_W;
    localparam logic EXOKAY_ACCEPT = (EXOKAY_OK != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              ar_hs_s, aw_hs_s, r_hs_s, b_hs_s, r_pop_s;
    logic              rd_full_s, rd_empty_s, wr_full_s, wr_empty_s;
    logic [ENT_W-1:0]  rd_head_s, wr_head_s;
    logic              rd_fault_s, wr_fault_s, any_fault_s;
    logic [ADDR_W-1:0] rd_addr_s, wr_addr_s;
    logic [ID_W-1:0]   rd_id_s, wr_id_s;
    logic              orphan_s, ovf_s;

    axi_fault_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_rd_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (ar_hs_s),
        .push_data ({araddr, arid}),
        .pop       (r_pop_s),
        .full      (rd_full_s),
        .empty     (rd_empty_s),
        .head      (rd_head_s)
    );

    axi_fault_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_wr_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (aw_hs_s),
        .push_data ({awaddr, awid}),
        .pop       (b_hs_s),
        .full      (wr_full_s),
        .empty     (wr_empty_s),
        .head      (wr_head_s)
    );

    // Handshake decode, fault classification and protocol-error detection
    always_comb begin
        ar_hs_s     = arvalid && arready;
        aw_hs_s     = awvalid && awready;
        r_hs_s      = rvalid && rready;
        b_hs_s      = bvalid && bready;
        r_pop_s     = r_hs_s && rlast;
        rd_fault_s  = r_hs_s && is_fault(rresp, EXOKAY_ACCEPT);
        wr_fault_s  = b_hs_s && is_fault(bresp, EXOKAY_ACCEPT);
        any_fault_s = rd_fault_s || wr_fault_s;

        // An empty tracker has no head; report address 0 and the beat's own ID
        if (rd_empty_s) begin
            rd_addr_s = {ADDR_W{1'b0}};
            rd_id_s   = rid;
        end else begin
            rd_addr_s = rd_head_s[ENT_W-1:ID_W];
            rd_id_s   = rd_head_s[ID_W-1:0];
        end
        if (wr_empty_s) begin
            wr_addr_s = {ADDR_W{1'b0}};
            wr_id_s   = bid;
        end else begin
            wr_addr_s = wr_head_s[ENT_W-1:ID_W];
            wr_id_s   = wr_head_s[ID_W-1:0];
        end

        orphan_s = (r_hs_s && (rd_empty_s || (rd_head_s[ID_W-1:0] != rid))) ||
                   (b_hs_s && (wr_empty_s || (wr_head_s[ID_W-1:0] != bid)));
        ovf_s    = (ar_hs_s && rd_full_s && !r_pop_s) ||
                   (aw_hs_s && wr_full_s && !b_hs_s);
    end

    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                  input logic hit, input logic clr);
        logic [CNT_W-1:0] base;
        base = clr ? {CNT_W{1'b0}} : cnt;
        if (hit && (base != CNT_MAX)) begin
            return base + CNT_W'(1);
        end else begin
            return base;
        end
    endfunction

    // Fault pulse and sticky protocol flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fault  <= 1'b0;
            o_ovf    <= 1'b0;
            o_orphan <= 1'b0;
        end else begin
            o_fault  <= any_fault_s;
            o_ovf    <= ovf_s || (o_ovf && !i_clr);
            o_orphan <= orphan_s || (o_orphan && !i_clr);
        end
    end

    // First-fault record; a fault coinciding with clear reloads it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rec_vld  <= 1'b0;
            o_rec_addr <= {ADDR_W{1'b0}};
            o_rec_id   <= {ID_W{1'b0}};
            o_rec_resp <= 2'b00;
            o_rec_wr   <= 1'b0;
        end else if (any_fault_s && (!o_rec_vld || i_clr)) begin
            o_rec_vld <= 1'b1;
            if (rd_fault_s) begin
                o_rec_addr <= rd_addr_s;
                o_rec_id   <= rd_id_s;
                o_rec_resp <= rresp;
                o_rec_wr   <= 1'b0;
            end else begin
                o_rec_addr <= wr_addr_s;
                o_rec_id   <= wr_id_s;
                o_rec_resp <= bresp;
                o_rec_wr   <= 1'b1;
            end
        end else if (i_clr) begin
            o_rec_vld  <= 1'b0;
            o_rec_addr <= {ADDR_W{1'b0}};
            o_rec_id   <= {ID_W{1'b0}};
            o_rec_resp <= 2'b00;
            o_rec_wr   <= 1'b0;
        end
    end

    // Saturating per-direction fault counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_cnt <= {CNT_W{1'b0}};
            o_wr_cnt <= {CNT_W{1'b0}};
        end else begin
            o_rd_cnt <= next_cnt(o_rd_cnt, rd_fault_s, i_clr);
            o_wr_cnt <= next_cnt(o_wr_cnt, wr_fault_s, i_clr);
        end
    end

endmodule

// File: tb/tb_axi_fault_monitor.sv
// Self-checking bench for axi_fault_monitor: a vector table plus hand-built
// sequences, with expected outputs queued at drive time and compared one cycle later.
module tb_axi_fault_monitor;
    import axi_fault_pkg::*;

    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    logic i_rst, i_clr;
    logic awvalid, awready, arvalid, arready, bvalid, bready, rvalid, rready, rlast;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [ID_W-1:0]   awid, arid, bid, rid;
    logic [1:0]        bresp, rresp;
    logic              o_fault, o_rec_vld, o_rec_wr, o_ovf, o_orphan;
    logic [ADDR_W-1:0] o_rec_addr;
    logic [ID_W-1:0]   o_rec_id;
    logic [1:0]        o_rec_resp;
    logic [CNT_W-1:0]  o_rd_cnt, o_wr_cnt;

    axi_fault_monitor #(
        .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .EXOKAY_OK(1)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_clr(i_clr),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp), .rid(rid),
        .o_fault(o_fault), .o_rec_vld(o_rec_vld), .o_rec_addr(o_rec_addr),
        .o_rec_id(o_rec_id), .o_rec_resp(o_rec_resp), .o_rec_wr(o_rec_wr),
        .o_rd_cnt(o_rd_cnt), .o_wr_cnt(o_wr_cnt), .o_ovf(o_ovf), .o_orphan(o_orphan)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       fault;
        logic       vld;
        fault_rec_t rec;
        logic [7:0] rd_cnt;
        logic [7:0] wr_cnt;
        logic       ovf;
        logic       orphan;
    } exp_t;

    typedef struct packed {
        logic        rst, clr, nr;
        logic        aw;
        logic [31:0] awaddr;
        logic [3:0]  awid;
        logic        ar;
        logic [31:0] araddr;
        logic [3:0]  arid;
        logic        b;
        logic [1:0]  bresp;
        logic [3:0]  bid;
        logic        r, rlast;
        logic [1:0]  rresp;
        logic [3:0]  rid;
        exp_t        e;
    } vec_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    exp_t ex;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    function automatic vec_t nv();
        vec_t v;
        v = '0;
        return v;
    endfunction

    function automatic vec_t w_ar(input vec_t vi, input logic [31:0] a, input logic [3:0] id);
        vec_t v;
        v = vi; v.ar = 1'b1; v.araddr = a; v.arid = id;
        return v;
    endfunction

    function automatic vec_t w_aw(input vec_t vi, input logic [31:0] a, input logic [3:0] id);
        vec_t v;
        v = vi; v.aw = 1'b1; v.awaddr = a; v.awid = id;
        return v;
    endfunction

    function automatic vec_t w_r(input vec_t vi, input resp_e resp, input logic [3:0] id,
                                 input logic last);
        vec_t v;
        v = vi; v.r = 1'b1; v.rresp = resp; v.rid = id; v.rlast = last;
        return v;
    endfunction

    function automatic vec_t w_b(input vec_t vi, input resp_e resp, input logic [3:0] id);
        vec_t v;
        v = vi; v.b = 1'b1; v.bresp = resp; v.bid = id;
        return v;
    endfunction

    function automatic vec_t w_clr(input vec_t vi);
        vec_t v;
        v = vi; v.clr = 1'b1;
        return v;
    endfunction

    task automatic set_rec(input logic [31:0] a, input logic [3:0] id, input resp_e resp,
                           input logic wr);
        ex.vld      = 1'b1;
        ex.rec.addr = 64'(a);
        ex.rec.id   = 16'(id);
        ex.rec.resp = resp;
        ex.rec.wr   = wr;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check(input exp_t e);
        chk("fault",    64'(o_fault),    64'(e.fault));
        chk("rec_vld",  64'(o_rec_vld),  64'(e.vld));
        chk("rec_addr", 64'(o_rec_addr), e.rec.addr);
        chk("rec_id",   64'(o_rec_id),   64'(e.rec.id));
        chk("rec_resp", 64'(o_rec_resp), 64'(e.rec.resp));
        chk("rec_wr",   64'(o_rec_wr),   64'(e.rec.wr));
        chk("rd_cnt",   64'(o_rd_cnt),   64'(e.rd_cnt));
        chk("wr_cnt",   64'(o_wr_cnt),   64'(e.wr_cnt));
        chk("ovf",      64'(o_ovf),      64'(e.ovf));
        chk("orphan",   64'(o_orphan),   64'(e.orphan));
    endtask

    task automatic apply(input vec_t v);
        i_rst   = v.rst;
        i_clr   = v.clr;
        awvalid = v.aw; awready = !v.nr; awaddr = v.awaddr; awid = v.awid;
        arvalid = v.ar; arready = !v.nr; araddr = v.araddr; arid = v.arid;
        bvalid  = v.b;  bready  = !v.nr; bresp  = v.bresp;  bid  = v.bid;
        rvalid  = v.r;  rready  = !v.nr; rresp  = v.rresp;  rid  = v.rid; rlast = v.rlast;
        exp_q.push_back(v.e);
        @(posedge clk);
        #1;
        cyc++;
        check(exp_q.pop_front());
    endtask

    task automatic add(input vec_t vi, input logic f);
        vec_t v;
        v = vi; v.e = ex; v.e.fault = f;
        tbl.push_back(v);
    endtask

    task automatic run(input vec_t vi, input logic f);
        vec_t v;
        v = vi; v.e = ex; v.e.fault = f;
        apply(v);
    endtask

    initial begin
        vec_t v;
        ex = '0;
        v = nv(); v.rst = 1'b1;
        add(v, 1'b0);
        add(nv(), 1'b0);
        // Single-beat read SLVERR
        add(w_ar(nv(), 32'h8000_0000, 4'd3), 1'b0);
        set_rec(32'h8000_0000, 4'd3, RESP_SLVERR, 1'b0); ex.rd_cnt = 8'd1;
        add(w_r(nv(), RESP_SLVERR, 4'd3, 1'b1), 1'b1);
        add(nv(), 1'b0);
        ex = '0;
        add(w_clr(nv()), 1'b0);
        // Second write faults, in-order head supplies the address
        add(w_aw(nv(), 32'h1000, 4'd1), 1'b0);
        add(w_aw(nv(), 32'h2000, 4'd2), 1'b0);
        add(w_b(nv(), RESP_OKAY, 4'd1), 1'b0);
        set_rec(32'h2000, 4'd2, RESP_DECERR, 1'b1); ex.wr_cnt = 8'd1;
        add(w_b(nv(), RESP_DECERR, 4'd2), 1'b1);
        ex = '0;
        add(w_clr(nv()), 1'b0);
        // Simultaneous read and write faults: read wins the record
        add(w_aw(w_ar(nv(), 32'hA0, 4'd5), 32'hB0, 4'd6), 1'b0);
        set_rec(32'hA0, 4'd5, RESP_SLVERR, 1'b0); ex.rd_cnt = 8'd1; ex.wr_cnt = 8'd1;
        add(w_b(w_r(nv(), RESP_SLVERR, 4'd5, 1'b1), RESP_DECERR, 4'd6), 1'b1);
        add(w_ar(nv(), 32'hC0, 4'd7), 1'b0);
        add(w_r(nv(), RESP_EXOKAY, 4'd7, 1'b1), 1'b0);
        // Non-last beat faults too, later faults keep the record
        add(w_ar(nv(), 32'hD0, 4'd8), 1'b0);
        ex.rd_cnt = 8'd2;
        add(w_r(nv(), RESP_SLVERR, 4'd8, 1'b0), 1'b1);
        add(w_r(nv(), RESP_OKAY, 4'd8, 1'b1), 1'b0);
        // Valid without ready is not a handshake
        v = w_r(w_ar(nv(), 32'hE0, 4'd0), RESP_SLVERR, 4'd0, 1'b1); v.nr = 1'b1;
        add(v, 1'b0);
        ex.orphan = 1'b1;
        add(w_r(nv(), RESP_OKAY, 4'd0, 1'b1), 1'b0);
        ex = '0;
        add(w_clr(nv()), 1'b0);
        // ID mismatch against tracker head
        add(w_aw(nv(), 32'hE0, 4'd9), 1'b0);
        ex.orphan = 1'b1;
        add(w_b(nv(), RESP_OKAY, 4'd4), 1'b0);
        ex = '0;
        add(w_clr(nv()), 1'b0);
        // Fault with empty tracker records address 0
        set_rec(32'h0, 4'd0, RESP_SLVERR, 1'b0); ex.rd_cnt = 8'd1; ex.orphan = 1'b1;
        add(w_r(nv(), RESP_SLVERR, 4'd0, 1'b1), 1'b1);
        ex = '0;
        add(w_clr(nv()), 1'b0);

        foreach (tbl[i]) begin
            apply(tbl[i]);
        end

        // Overflow, then push+pop while full and in-order drain
        for (int i = 0; i < DEPTH; i++) begin
            run(w_ar(nv(), 32'h100 + 32'(i) * 32'h10, 4'(i)), 1'b0);
        end
        ex.ovf = 1'b1;
        run(w_ar(nv(), 32'h140, 4'd4), 1'b0);
        ex = '0;
        run(w_clr(nv()), 1'b0);
        run(w_r(w_ar(nv(), 32'h200, 4'hA), RESP_OKAY, 4'd0, 1'b1), 1'b0);
        set_rec(32'h110, 4'd1, RESP_SLVERR, 1'b0); ex.rd_cnt = 8'd1;
        run(w_r(nv(), RESP_SLVERR, 4'd1, 1'b1), 1'b1);
        run(w_r(nv(), RESP_OKAY, 4'd2, 1'b1), 1'b0);
        run(w_r(nv(), RESP_OKAY, 4'd3, 1'b1), 1'b0);
        run(w_r(nv(), RESP_OKAY, 4'hA, 1'b1), 1'b0);
        ex.orphan = 1'b1;
        run(w_r(nv(), RESP_OKAY, 4'd0, 1'b1), 1'b0);
        ex = '0;
        run(w_clr(nv()), 1'b0);

        // Counter saturation over 2^CNT_W+3 faulting beats
        run(w_ar(nv(), 32'h300, 4'd2), 1'b0);
        set_rec(32'h300, 4'd2, RESP_SLVERR, 1'b0);
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            ex.rd_cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            run(w_r(nv(), RESP_SLVERR, 4'd2, 1'b0), 1'b1);
        end
        run(w_r(nv(), RESP_OKAY, 4'd2, 1'b1), 1'b0);

        // Clear coincident with a fault: the fault wins
        run(w_aw(nv(), 32'h600, 4'd1), 1'b0);
        ex.wr_cnt = 8'd1;
        run(w_b(nv(), RESP_SLVERR, 4'd1), 1'b1);
        run(w_ar(nv(), 32'h400, 4'd3), 1'b0);
        ex = '0;
        set_rec(32'h400, 4'd3, RESP_SLVERR, 1'b0); ex.rd_cnt = 8'd1;
        run(w_r(w_clr(nv()), RESP_SLVERR, 4'd3, 1'b1), 1'b1);

        // Reset with reads outstanding discards the tracker
        run(w_ar(nv(), 32'h500, 4'd1), 1'b0);
        run(w_ar(nv(), 32'h510, 4'd2), 1'b0);
        ex = '0;
        v = nv(); v.rst = 1'b1;
        run(v, 1'b0);
        ex.orphan = 1'b1;
        run(w_r(nv(), RESP_OKAY, 4'd1, 1'b1), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d got timeout expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
